// File: rtl/usr_shift_sequencer.sv
// Command sequencer for an N-bit universal shift register.
// Ports: clk, reset_n; cmd_valid/cmd_ready + cmd_op/amt/data/fill; abort;
// q (register feedback); sel, msb_in, lsb_in, load_data; busy, done, aborted.
module usr_shift_sequencer #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [CW-1:0] cmd_amt,
    input  logic [N-1:0]  cmd_data,
    input  logic          cmd_fill,
    input  logic          abort,
    input  logic [N-1:0]  q,
    output logic [1:0]    sel,
    output logic          msb_in,
    output logic          lsb_in,
    output logic [N-1:0]  load_data,
    output logic          busy,
    output logic          done,
    output logic          aborted
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_ROL  = 2'b11;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [N-1:0]  data_q, data_d;
    logic          fill_q, fill_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          aborted_q, aborted_d;
    logic [CW-1:0] amt_clamp;

    // Only the MSB of q feeds back (rotate left); the rest is not needed.
    logic unused_q;
    assign unused_q = ^q[N-2:0];

    assign amt_clamp = (cmd_amt > CW'(N)) ? CW'(N) : cmd_amt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            op_q      <= OP_LOAD;
            data_q    <= '0;
            fill_q    <= 1'b0;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            data_q    <= data_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        data_d    = data_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        aborted_d = 1'b0;
        sel       = SEL_HOLD;
        msb_in    = 1'b0;
        lsb_in    = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    data_d = cmd_data;
                    fill_d = cmd_fill;
                    cnt_d  = amt_clamp;
                    if (cmd_op == OP_LOAD) begin
                        state_d = LOAD;
                    end else if (amt_clamp == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            LOAD: begin
                sel     = SEL_LOAD;
                state_d = DONE;
            end
            SHIFT: begin
                unique case (1'b1)
                    op_q == OP_SHR: begin
                        sel    = SEL_SHR;
                        msb_in = fill_q;
                    end
                    op_q == OP_SHL: begin
                        sel    = SEL_SHL;
                        lsb_in = fill_q;
                    end
                    op_q == OP_ROL: begin
                        sel    = SEL_SHL;
                        lsb_in = q[N-1];
                    end
                    default: ;
                endcase
                if (abort) begin
                    // Hold on the abort edge so completed steps stay put.
                    sel       = SEL_HOLD;
                    cnt_d     = '0;
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign load_data = data_q;
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Testbench for usr_shift_sequencer with a behavioural shift register plant
// and an arithmetic reference model of each command's effect.
module tb_usr_shift_sequencer;

    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    logic          clk;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [CW-1:0] cmd_amt;
    logic [N-1:0]  cmd_data;
    logic          cmd_fill;
    logic          abort;
    logic [N-1:0]  q;
    logic [1:0]    sel;
    logic          msb_in;
    logic          lsb_in;
    logic [N-1:0]  load_data;
    logic          busy;
    logic          done;
    logic          aborted;

    int vectors;
    int miscompares;
    logic [N-1:0] mq;

    usr_shift_sequencer #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .cmd_data  (cmd_data),
        .cmd_fill  (cmd_fill),
        .abort     (abort),
        .q         (q),
        .sel       (sel),
        .msb_in    (msb_in),
        .lsb_in    (lsb_in),
        .load_data (load_data),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The universal shift register being sequenced.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else begin
            case (sel)
                2'b01:   q <= {msb_in, q[N-1:1]};
                2'b10:   q <= {q[N-2:0], lsb_in};
                2'b11:   q <= load_data;
                default: ;
            endcase
        end
    end

    function automatic logic [N-1:0] model(input logic [1:0] op,
                                           input int amt,
                                           input logic [N-1:0] cur,
                                           input logic [N-1:0] data,
                                           input logic fill);
        int k;
        logic [2*N-1:0] w;
        k = (amt > N) ? N : amt;
        case (op)
            2'b00: return data;
            2'b01: begin
                w = {{N{fill}}, cur} >> k;
                return w[N-1:0];
            end
            2'b10: begin
                w = {cur, {N{fill}}} << k;
                return w[2*N-1:N];
            end
            default: begin
                w = {cur, cur} << k;
                return w[2*N-1:N];
            end
        endcase
    endfunction

    function automatic int steps(input logic [1:0] op, input int amt);
        if (op == 2'b00) return 1;
        return (amt > N) ? N : amt;
    endfunction

    // Issue one command from IDLE and watch it until cmd_ready returns.
    // lat = edges from acceptance to the next possible acceptance (-1 on timeout).
    task automatic issue(input logic [1:0] op, input logic [CW-1:0] amt,
                         input logic [N-1:0] data, input logic fill,
                         output int nsel_ok, output int nsel_any,
                         output int ndone, output int done_i,
                         output int lat, output int nbad);
        logic [1:0] exp_sel;
        exp_sel = (op == 2'b00) ? 2'b11 : (op == 2'b01) ? 2'b01 : 2'b10;
        nsel_ok = 0; nsel_any = 0; ndone = 0;
        done_i = -1; lat = -1; nbad = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_amt   = amt;
        cmd_data  = data;
        cmd_fill  = fill;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sel == exp_sel) nsel_ok++;
            if (sel != 2'b00) nsel_any++;
            if (done) begin
                ndone++;
                if (done_i < 0) done_i = i;
            end
            if (busy !== !cmd_ready || aborted) nbad++;
            if (cmd_ready) begin
                lat = i + 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00;
        cmd_amt = '0; cmd_data = '0; cmd_fill = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        mq = '0;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready got %0b want 1", cmd_ready);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy got %0b want 0", busy);
        end
        vectors++;
        if (sel !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_sel got %b want 00", sel);
        end
        vectors++;
        if (done !== 1'b0 || aborted !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pulses got done=%0b aborted=%0b want 0/0",
                     done, aborted);
        end
        vectors++;
        if (load_data !== '0) begin
            miscompares++;
            $display("FAIL reset_load_data got %h want 00", load_data);
        end
    endtask

    task automatic test_load;
        int so, sa, nd, di, lat, nb;
        issue(2'b00, '0, 8'hA5, 1'b0, so, sa, nd, di, lat, nb);
        mq = 8'hA5;
        vectors++;
        if (so !== 1 || sa !== 1) begin
            miscompares++;
            $display("FAIL load_sel got ok=%0d any=%0d want 1/1", so, sa);
        end
        vectors++;
        if (q !== 8'hA5) begin
            miscompares++;
            $display("FAIL load_q got %h want a5", q);
        end
        vectors++;
        if (nd !== 1 || di !== 1) begin
            miscompares++;
            $display("FAIL load_done got n=%0d at %0d want 1 at 1", nd, di);
        end
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL load_latency got %0d want 3", lat);
        end
    endtask

    task automatic test_shift_right;
        int so, sa, nd, di, lat, nb;
        issue(2'b01, CW'(3), 8'h00, 1'b1, so, sa, nd, di, lat, nb);
        mq = model(2'b01, 3, mq, 8'h00, 1'b1);
        vectors++;
        if (q !== 8'hF4 || q !== mq) begin
            miscompares++;
            $display("FAIL shr_q got %h want f4", q);
        end
        vectors++;
        if (so !== 3 || sa !== 3) begin
            miscompares++;
            $display("FAIL shr_sel got ok=%0d any=%0d want 3/3", so, sa);
        end
        vectors++;
        if (nd !== 1 || di !== 3 || lat !== 5) begin
            miscompares++;
            $display("FAIL shr_timing got n=%0d at %0d lat %0d want 1 at 3 lat 5",
                     nd, di, lat);
        end
    endtask

    task automatic test_rotate_clamp;
        int so, sa, nd, di, lat, nb;
        issue(2'b00, '0, 8'h81, 1'b0, so, sa, nd, di, lat, nb);
        issue(2'b11, CW'(1), 8'h00, 1'b0, so, sa, nd, di, lat, nb);
        vectors++;
        if (q !== 8'h03) begin
            miscompares++;
            $display("FAIL rol1_q got %h want 03", q);
        end
        issue(2'b11, CW'(15), 8'h00, 1'b0, so, sa, nd, di, lat, nb);
        mq = 8'h03;
        vectors++;
        if (q !== 8'h03) begin
            miscompares++;
            $display("FAIL rol_clamp_q got %h want 03", q);
        end
        vectors++;
        if (so !== 8 || sa !== 8 || lat !== 10 || nd !== 1) begin
            miscompares++;
            $display("FAIL rol_clamp_cycles got sel=%0d/%0d lat %0d done %0d want 8/8 10 1",
                     so, sa, lat, nd);
        end
    endtask

    task automatic test_zero_and_held;
        int so, sa, nd, di, lat, nb, acc, ns;
        issue(2'b10, '0, 8'h00, 1'b1, so, sa, nd, di, lat, nb);
        vectors++;
        if (sa !== 0 || q !== mq) begin
            miscompares++;
            $display("FAIL zero_amt got sel cycles %0d q %h want 0 %h", sa, q, mq);
        end
        vectors++;
        if (nd !== 1 || di !== 0 || lat !== 2) begin
            miscompares++;
            $display("FAIL zero_timing got n=%0d at %0d lat %0d want 1 at 0 lat 2",
                     nd, di, lat);
        end
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_amt = CW'(2);
        cmd_data = 8'h00; cmd_fill = 1'b1;
        acc = 0; ns = 0;
        for (int c = 0; c < 9; c++) begin
            if (cmd_ready) acc++;
            if (sel == 2'b10) ns++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        lat = -1;
        for (int j = 0; j < 20; j++) begin
            if (sel == 2'b10) ns++;
            if (cmd_ready) begin
                lat = j;
                break;
            end
            @(negedge clk);
        end
        for (int r = 0; r < 3; r++) mq = model(2'b10, 2, mq, 8'h00, 1'b1);
        vectors++;
        if (acc !== 3 || lat < 0) begin
            miscompares++;
            $display("FAIL held_valid got %0d accepts (idle %0d) want 3", acc, lat);
        end
        vectors++;
        if (ns !== 6 || q !== mq) begin
            miscompares++;
            $display("FAIL held_result got %0d shifts q %h want 6 %h", ns, q, mq);
        end
    endtask

    task automatic test_abort;
        int so, sa, nd, di, lat, nb;
        issue(2'b00, '0, 8'hFF, 1'b0, so, sa, nd, di, lat, nb);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_amt = CW'(6);
        cmd_data = 8'h00; cmd_fill = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        sa = 0;
        for (int i = 0; i < 2; i++) begin
            if (sel == 2'b10) sa++;
            @(negedge clk);
        end
        abort = 1'b1;
        #1;
        vectors++;
        if (sa !== 2 || sel !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_sel got %0d shifts, abort sel %b want 2 00", sa, sel);
        end
        @(negedge clk);
        abort = 1'b0;
        mq = model(2'b10, 2, 8'hFF, 8'h00, 1'b0);
        vectors++;
        if (aborted !== 1'b1 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_pulse got aborted=%0b done=%0b ready=%0b want 1 0 1",
                     aborted, done, cmd_ready);
        end
        vectors++;
        if (q !== mq) begin
            miscompares++;
            $display("FAIL abort_q got %h want %h", q, mq);
        end
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || aborted) nd++;
        end
        vectors++;
        if (nd !== 0) begin
            miscompares++;
            $display("FAIL abort_after got %0d pulses want 0", nd);
        end
    endtask

    task automatic test_reset_mid;
        int np;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_amt = CW'(8);
        cmd_data = 8'h00; cmd_fill = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        vectors++;
        if (sel !== 2'b00 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid got sel=%b ready=%0b busy=%0b want 00 1 0",
                     sel, cmd_ready, busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        mq = '0;
        np = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || aborted || sel != 2'b00) np++;
            @(negedge clk);
        end
        vectors++;
        if (np !== 0 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_after got %0d active cycles ready=%0b want 0 1",
                     np, cmd_ready);
        end
    endtask

    task automatic test_random;
        int so, sa, nd, di, lat, nb, k, amt;
        logic [1:0] op;
        logic [N-1:0] data, exp_q;
        logic fill;
        for (int t = 0; t < 40; t++) begin
            op   = 2'($urandom_range(0, 3));
            amt  = $urandom_range(0, 15);
            data = N'($urandom);
            fill = 1'($urandom);
            k    = steps(op, amt);
            exp_q = model(op, amt, mq, data, fill);
            issue(op, CW'(amt), data, fill, so, sa, nd, di, lat, nb);
            mq = exp_q;
            vectors++;
            if (q !== exp_q) begin
                miscompares++;
                $display("FAIL rnd%0d_q op %0d amt %0d got %h want %h",
                         t, op, amt, q, exp_q);
            end
            vectors++;
            if (so !== k || sa !== k) begin
                miscompares++;
                $display("FAIL rnd%0d_sel op %0d amt %0d got %0d/%0d want %0d",
                         t, op, amt, so, sa, k);
            end
            vectors++;
            if (nd !== 1 || di !== ((op == 2'b00) ? 1 : k)) begin
                miscompares++;
                $display("FAIL rnd%0d_done got n=%0d at %0d want 1 at %0d",
                         t, nd, di, (op == 2'b00) ? 1 : k);
            end
            vectors++;
            if (lat !== ((op == 2'b00) ? 3 : k + 2)) begin
                miscompares++;
                $display("FAIL rnd%0d_latency got %0d want %0d",
                         t, lat, (op == 2'b00) ? 3 : k + 2);
            end
            vectors++;
            if (nb !== 0) begin
                miscompares++;
                $display("FAIL rnd%0d_flags got %0d bad cycles want 0", t, nb);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        mq = '0;
        test_reset;
        test_load;
        test_shift_right;
        test_rotate_clamp;
        test_zero_and_held;
        test_abort;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
